router_fsm: RTL and testbench

//  Packet-level controller for the 1x3 router. Sequences the input register, the synchronizer
//  and the three output FIFOs for each packet: header/address decode, first-byte load, payload,

---
 rtl/router_pkg.sv | 38 +++
 rtl/router_fsm.sv | 134 +++++++++++++
 tb/tb_router_fsm.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router packet controller.
//   ADDR_W / NUM_DEST : header address width and number of output FIFOs
//   ADDR_*            : destination address codes; ADDR_INVALID has no FIFO behind it
//   state_e           : 3-bit controller state encoding (all eight codes are used)
//   pick_dest         : select one per-FIFO flag by destination address
package router_pkg;

   localparam int unsigned ADDR_W   = 2;
   localparam int unsigned NUM_DEST = 3;

   localparam logic [ADDR_W-1:0] ADDR_0       = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_1       = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_2       = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

   typedef enum logic [2:0] {
      StDecodeAddress   = 3'd0,
      StLoadFirstData   = 3'd1,
      StLoadData        = 3'd2,
      StFifoFull        = 3'd3,
      StLoadAfterFull   = 3'd4,
      StLoadParity      = 3'd5,
      StCheckParityErr  = 3'd6,
      StWaitTillEmpty   = 3'd7
   } state_e;

   // Flag of the addressed FIFO; the invalid address has no FIFO and reads as 0.
   function automatic logic pick_dest(input logic [NUM_DEST-1:0] flags,
                                      input logic [ADDR_W-1:0]   addr);
      case (addr)
         ADDR_0:  return flags[0];
         ADDR_1:  return flags[1];
         ADDR_2:  return flags[2];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-level controller for the 1x3 router. Sequences header decode, first-byte load,
// payload, FIFO-full stall, parity load and parity check for each packet.
// Ports:
//   clk, reset_in (sync, active-low)
//   pkt_valid, data_in[1:0]           : input port; data_in is the header address
//   fifo_full                         : full flag of the addressed FIFO
//   fifo_empty_0..2, soft_reset_0..2  : per-FIFO empty and timeout-reset flags
//   parity_done, low_pkt_valid        : status from the input register
//   detect_add, lfd_state, ld_state, laf_state, full_state : state strobes
//   write_en_reg, rst_int_reg, busy   : datapath enables and source back-pressure
module router_fsm
   import router_pkg::*;
(
   input  logic              clk,
   input  logic              reset_in,
   input  logic              pkt_valid,
   input  logic [ADDR_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              fifo_empty_0,
   input  logic              fifo_empty_1,
   input  logic              fifo_empty_2,
   input  logic              soft_reset_0,
   input  logic              soft_reset_1,
   input  logic              soft_reset_2,
   input  logic              parity_done,
   input  logic              low_pkt_valid,
   output logic              detect_add,
   output logic              lfd_state,
   output logic              ld_state,
   output logic              laf_state,
   output logic              full_state,
   output logic              write_en_reg,
   output logic              rst_int_reg,
   output logic              busy
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [NUM_DEST-1:0] empty_vec, soft_vec;

   assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};

   always_ff @(posedge clk) begin
      if (!reset_in) begin
         state_q <= StDecodeAddress;
         addr_q  <= ADDR_0;
      end else begin
         state_q <= state_d;
         if (state_q == StDecodeAddress && pkt_valid) begin
            addr_q <= data_in;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      // A timeout on the packet's FIFO abandons the packet from any active state.
      if (state_q != StDecodeAddress && pick_dest(soft_vec, addr_q)) begin
         state_d = StDecodeAddress;
      end else begin
         case (state_q)
            StDecodeAddress: begin
               if (pkt_valid && data_in != ADDR_INVALID) begin
                  state_d = pick_dest(empty_vec, data_in) ? StLoadFirstData : StWaitTillEmpty;
               end
            end
            StLoadFirstData: state_d = StLoadData;
            StLoadData: begin
               // fifo_full takes precedence so a parity byte arriving during a stall
               // is written through LOAD_AFTER_FULL.
               if (fifo_full)       state_d = StFifoFull;
               else if (!pkt_valid) state_d = StLoadParity;
            end
            StFifoFull: begin
               if (!fifo_full) state_d = StLoadAfterFull;
            end
            StLoadAfterFull: begin
               if (parity_done)        state_d = StDecodeAddress;
               else if (low_pkt_valid) state_d = StLoadParity;
               else                    state_d = StLoadData;
            end
            StLoadParity:     state_d = StCheckParityErr;
            StCheckParityErr: state_d = fifo_full ? StFifoFull : StDecodeAddress;
            StWaitTillEmpty: begin
               if (pick_dest(empty_vec, addr_q)) state_d = StLoadFirstData;
            end
            default:          state_d = StDecodeAddress;
         endcase
      end
   end

   always_comb begin
      detect_add   = 1'b0;
      lfd_state    = 1'b0;
      ld_state     = 1'b0;
      laf_state    = 1'b0;
      full_state   = 1'b0;
      write_en_reg = 1'b0;
      rst_int_reg  = 1'b0;
      busy         = 1'b0;
      case (state_q)
         StDecodeAddress:  detect_add = 1'b1;
         StLoadFirstData: begin
            lfd_state = 1'b1;
            busy      = 1'b1;
         end
         StLoadData: begin
            ld_state     = 1'b1;
            write_en_reg = 1'b1;
         end
         StFifoFull: begin
            full_state = 1'b1;
            busy       = 1'b1;
         end
         StLoadAfterFull: begin
            laf_state    = 1'b1;
            write_en_reg = 1'b1;
            busy         = 1'b1;
         end
         StLoadParity: begin
            write_en_reg = 1'b1;
            busy         = 1'b1;
         end
         StCheckParityErr: begin
            rst_int_reg = 1'b1;
            busy        = 1'b1;
         end
         StWaitTillEmpty:  busy = 1'b1;
         default:          detect_add = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed packet scenarios followed by randomized
// inputs, every cycle compared against a packet-phase reference model.
module tb_router_fsm;

   logic       clk = 1'b0;
   logic       reset_in, pkt_valid, fifo_full, parity_done, low_pkt_valid;
   logic [1:0] data_in;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       write_en_reg, rst_int_reg, busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   router_fsm dut (
      .clk           (clk),
      .reset_in      (reset_in),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .fifo_empty_0  (fifo_empty_0),
      .fifo_empty_1  (fifo_empty_1),
      .fifo_empty_2  (fifo_empty_2),
      .soft_reset_0  (soft_reset_0),
      .soft_reset_1  (soft_reset_1),
      .soft_reset_2  (soft_reset_2),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .write_en_reg  (write_en_reg),
      .rst_int_reg   (rst_int_reg),
      .busy          (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference model: packet phase plus the destination captured from the header.
   typedef enum int {PDecode, PFirst, PLoad, PFull, PAfterFull, PParity, PCheck, PWait} phase_t;
   phase_t     m_phase = PDecode;
   logic [1:0] m_addr  = 2'd0;

   // Expected {detect_add, lfd, ld, laf, full, write_en, rst_int, busy} for each phase.
   function automatic logic [7:0] exp_outs(input phase_t p);
      case (p)
         PDecode:    return 8'b1000_0000;
         PFirst:     return 8'b0100_0001;
         PLoad:      return 8'b0010_0100;
         PFull:      return 8'b0000_1001;
         PAfterFull: return 8'b0001_0101;
         PParity:    return 8'b0000_0101;
         PCheck:     return 8'b0000_0011;
         default:    return 8'b0000_0001;
      endcase
   endfunction

   function automatic logic flag_of(input logic [2:0] flags, input logic [1:0] a);
      return (a == 2'd3) ? 1'b0 : flags[a];
   endfunction

   task automatic model_clock();
      logic [2:0] emp, sr;
      phase_t     nxt;
      emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
      sr  = {soft_reset_2, soft_reset_1, soft_reset_0};
      if (!reset_in) begin
         m_phase = PDecode;
         m_addr  = 2'd0;
         return;
      end
      nxt = m_phase;
      if (m_phase != PDecode && flag_of(sr, m_addr)) nxt = PDecode;
      else begin
         case (m_phase)
            PDecode:    if (pkt_valid && data_in != 2'd3)
                           nxt = flag_of(emp, data_in) ? PFirst : PWait;
            PFirst:     nxt = PLoad;
            PLoad:      nxt = fifo_full ? PFull : (!pkt_valid ? PParity : PLoad);
            PFull:      nxt = fifo_full ? PFull : PAfterFull;
            PAfterFull: nxt = parity_done ? PDecode : (low_pkt_valid ? PParity : PLoad);
            PParity:    nxt = PCheck;
            PCheck:     nxt = fifo_full ? PFull : PDecode;
            default:    nxt = flag_of(emp, m_addr) ? PFirst : PWait;
         endcase
      end
      if (m_phase == PDecode && pkt_valid) m_addr = data_in;
      m_phase = nxt;
   endtask

   // One clock: model and DUT both advance on the edge, outputs compared 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
      check_eq("outs", {detect_add, lfd_state, ld_state, laf_state, full_state,
                        write_en_reg, rst_int_reg, busy}, {24'd0, exp_outs(m_phase)});
   endtask

   task automatic idle_inputs();
      reset_in = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
      fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
      parity_done = 1'b0; low_pkt_valid = 1'b0;
   endtask

   int wr_cycles;

   initial begin
      idle_inputs();
      // 1: reset
      reset_in = 1'b0;
      tick(); tick();
      check_eq("rst_detect_add", detect_add, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_write_en", write_en_reg, 0);
      reset_in = 1'b1;

      // 2: normal packet to FIFO 1 with four payload bytes
      pkt_valid = 1'b1; data_in = 2'd1;
      wr_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 5) pkt_valid = 1'b0;
         tick();
         if (write_en_reg) wr_cycles++;
      end
      check_eq("pkt_wr_cycles", wr_cycles, 5);
      check_eq("pkt_back_to_decode", detect_add, 1);

      // 3: wait for FIFO 2 to drain
      pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
      tick(); check_eq("wait_busy", busy, 1);
      tick(); check_eq("wait_hold_busy", busy, 1);
      fifo_empty_2 = 1'b1;
      tick(); check_eq("wait_to_lfd", lfd_state, 1);
      pkt_valid = 1'b0;
      repeat (4) tick();

      // 4: FIFO-full stall, parity delivered after release
      pkt_valid = 1'b1; data_in = 2'd0;
      tick(); tick();
      fifo_full = 1'b1;
      tick(); check_eq("full_no_write", write_en_reg, 0);
      fifo_full = 1'b0; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
      tick(); check_eq("laf_state", laf_state, 1);
      tick(); tick(); check_eq("cpe_rst_int", rst_int_reg, 1);
      low_pkt_valid = 1'b0;
      tick();

      // 5: soft resets, only the addressed FIFO counts
      pkt_valid = 1'b1; data_in = 2'd0;
      tick(); tick();
      soft_reset_1 = 1'b1;
      tick(); check_eq("other_soft_reset", ld_state, 1);
      soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
      tick(); check_eq("own_soft_reset", detect_add, 1);
      soft_reset_0 = 1'b0;

      // 6: invalid address is dropped
      pkt_valid = 1'b1; data_in = 2'd3;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 9) check_eq("invalid_addr_busy", busy, 0);
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset_in      = ($urandom_range(0, 99) != 0);
         pkt_valid     = ($urandom_range(0, 9) < 7);
         data_in       = 2'($urandom_range(0, 3));
         fifo_full     = ($urandom_range(0, 4) == 0);
         fifo_empty_0  = 1'($urandom);
         fifo_empty_1  = 1'($urandom);
         fifo_empty_2  = 1'($urandom);
         soft_reset_0  = ($urandom_range(0, 29) == 0);
         soft_reset_1  = ($urandom_range(0, 29) == 0);
         soft_reset_2  = ($urandom_range(0, 29) == 0);
         parity_done   = ($urandom_range(0, 4) == 0);
         low_pkt_valid = 1'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
